seq_detect_ctrl: RTL and testbench

//  Programmable serial-pattern detection controller for the 7-segment sequence-detector tile.
//  - Loads a 1..MAX_LEN bit target pattern over a serial config port.
//  - Arms detection against a qualified data bit stream; overlapping matches are counted.
//  - Sequences the 7-seg display: hex match count, decimal point flashed per match.

---
 rtl/seq_detect_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_detect_ctrl : programmable serial-pattern detector driving a 7-seg digit
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_ena,
  input  logic                       i_cfg_load,
  input  logic [$clog2(MAX_LEN)-1:0] i_cfg_len,
  input  logic                       i_cfg_bit,
  input  logic                       i_cfg_valid,
  input  logic                       i_data_bit,
  input  logic                       i_data_valid,
  input  logic                       i_clear,
  output logic                       o_busy,
  output logic                       o_armed,
  output logic                       o_match,
  output logic [3:0]                 o_match_count,
  output logic [7:0]                 o_seg
);

  localparam int c_len_w  = $clog2(MAX_LEN);
  localparam int c_cnt_w  = $clog2(MAX_LEN + 1);
  localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DETECT = 2'd2
  } state_t;

  state_t               r_state;
  logic [MAX_LEN-1:0]   r_pattern;
  logic [c_len_w-1:0]   r_len;
  logic [c_len_w-1:0]   r_bit_cnt;
  logic [MAX_LEN-1:0]   r_history;
  logic [c_cnt_w-1:0]   r_hist_cnt;
  logic [c_hold_w-1:0]  r_hold;
  logic                 r_match;
  logic [3:0]           r_count;

  logic [MAX_LEN-1:0]   w_hist_next;
  logic [MAX_LEN-1:0]   w_mask;
  logic [c_cnt_w-1:0]   w_len_p1;
  logic                 w_hist_full;
  logic                 w_hit;
  logic [6:0]           w_font;

  assign w_hist_next = {r_history[MAX_LEN-2:0], i_data_bit};
  assign w_len_p1    = c_cnt_w'(r_len) + c_cnt_w'(1);
  // hist_cnt+1 >= len+1 reduces to hist_cnt >= len
  assign w_hist_full = (r_hist_cnt >= c_cnt_w'(r_len));

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (c_len_w'(gi) <= r_len);
  end

  assign w_hit = (r_state == S_DETECT) && i_data_valid && w_hist_full &&
                 (((w_hist_next ^ r_pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pattern  <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_history  <= '0;
      r_hist_cnt <= '0;
      r_hold     <= '0;
      r_match    <= 1'b0;
      r_count    <= 4'd0;
    end else if (i_ena) begin
      r_match <= 1'b0;
      if (r_hold != '0) r_hold <= r_hold - c_hold_w'(1);

      if (i_cfg_load) begin
        r_state   <= S_LOAD;
        r_len     <= i_cfg_len;
        r_bit_cnt <= '0;
      end else if (i_clear) begin
        r_count    <= 4'd0;
        r_history  <= '0;
        r_hist_cnt <= '0;
        r_hold     <= '0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD: begin
            if (i_cfg_valid) begin
              r_pattern <= {r_pattern[MAX_LEN-2:0], i_cfg_bit};
              r_bit_cnt <= r_bit_cnt + c_len_w'(1);
              if (r_bit_cnt == r_len) begin
                r_state    <= S_DETECT;
                r_history  <= '0;
                r_hist_cnt <= '0;
              end
            end
          end
          S_DETECT: begin
            if (i_data_valid) begin
              r_history <= w_hist_next;
              if (r_hist_cnt != w_len_p1) r_hist_cnt <= r_hist_cnt + c_cnt_w'(1);
              if (w_hit) begin
                r_match <= 1'b1;
                r_hold  <= c_hold_load;
                if (r_count != 4'hF) r_count <= r_count + 4'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_font = 7'h00;
    case (r_count)
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h6F;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      4'hF: w_font = 7'h71;
      default: w_font = 7'h00;
    endcase
  end

  assign o_seg         = {(r_hold != '0), w_font};
  assign o_busy        = (r_state == S_LOAD);
  assign o_armed       = (r_state == S_DETECT);
  assign o_match       = r_match;
  assign o_match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_detect_ctrl : directed self-checking bench for seq_detect_ctrl
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst_n;
  logic       r_ena;
  logic       r_cfg_load;
  logic [2:0] r_cfg_len;
  logic       r_cfg_bit;
  logic       r_cfg_valid;
  logic       r_data_bit;
  logic       r_data_valid;
  logic       r_clear;
  logic       w_busy;
  logic       w_armed;
  logic       w_match;
  logic [3:0] w_count;
  logic [7:0] w_seg;

  int n_total = 0;
  int n_bad   = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .HOLD_CYCLES(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ena         (r_ena),
    .i_cfg_load    (r_cfg_load),
    .i_cfg_len     (r_cfg_len),
    .i_cfg_bit     (r_cfg_bit),
    .i_cfg_valid   (r_cfg_valid),
    .i_data_bit    (r_data_bit),
    .i_data_valid  (r_data_valid),
    .i_clear       (r_clear),
    .o_busy        (w_busy),
    .o_armed       (w_armed),
    .o_match       (w_match),
    .o_match_count (w_count),
    .o_seg         (w_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [2:0] len);
    r_cfg_load = 1'b1;
    r_cfg_len  = len;
    tick();
    r_cfg_load = 1'b0;
  endtask

  task automatic cfg_send(input logic b);
    r_cfg_bit   = b;
    r_cfg_valid = 1'b1;
    tick();
    r_cfg_valid = 1'b0;
  endtask

  task automatic data_send(input logic b);
    r_data_bit   = b;
    r_data_valid = 1'b1;
    tick();
    r_data_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] t1_stream;
    logic [6:0] t1_exp;
    t1_stream = 7'b1011011;
    t1_exp    = 7'b0001001;

    rst_n = 1'b0; r_ena = 1'b1; r_cfg_load = 1'b0; r_cfg_len = 3'd0;
    r_cfg_bit = 1'b0; r_cfg_valid = 1'b0; r_data_bit = 1'b0;
    r_data_valid = 1'b0; r_clear = 1'b0;
    tick(); tick();
    chk("rst_busy",  w_busy,  0);
    chk("rst_armed", w_armed, 0);
    chk("rst_match", w_match, 0);
    chk("rst_count", w_count, 0);
    chk("rst_seg",   w_seg,   8'h3F);
    rst_n = 1'b1;
    tick();

    // T1: pattern 1011, overlapping stream
    start_load(3'd3);
    chk("t1_busy", w_busy, 1);
    cfg_send(1); cfg_send(0); cfg_send(1);
    chk("t1_busy_mid", w_busy, 1);
    cfg_send(1);
    chk("t1_armed", w_armed, 1);
    for (int i = 0; i < 7; i++) begin
      data_send(t1_stream[6-i]);
      chk($sformatf("t1_match%0d", i), w_match, t1_exp[6-i]);
    end
    chk("t1_count", w_count, 2);
    chk("t1_seg", w_seg, 8'hDB);
    tick();
    chk("t1_pulse_end", w_match, 0);
    chk("t1_seg_hold", w_seg, 8'hDB);
    tick(); tick(); tick();
    chk("t1_seg_dp_off", w_seg, 8'h5B);

    // T2: 1-bit pattern, saturation
    r_clear = 1'b1; tick(); r_clear = 1'b0;
    chk("t2_clear_cnt", w_count, 0);
    chk("t2_clear_armed", w_armed, 1);
    start_load(3'd0);
    cfg_send(1);
    chk("t2_armed", w_armed, 1);
    for (int i = 1; i <= 20; i++) begin
      data_send(1);
      chk($sformatf("t2_match%0d", i), w_match, 1);
      chk($sformatf("t2_cnt%0d", i), w_count, (i > 15) ? 15 : i);
    end
    chk("t2_seg", w_seg, 8'hF1);

    // T3: reset mid-load
    start_load(3'd3);
    cfg_send(1); cfg_send(0);
    rst_n = 1'b0;
    #2;
    chk("t3_busy", w_busy, 0);
    chk("t3_armed", w_armed, 0);
    chk("t3_seg", w_seg, 8'h3F);
    tick();
    rst_n = 1'b1;
    tick();
    data_send(1); data_send(0); data_send(1); data_send(1);
    chk("t3_nomatch", w_match, 0);
    chk("t3_count", w_count, 0);
    chk("t3_idle", w_armed, 0);

    // T4: clear coincident with completing bit
    start_load(3'd1);
    cfg_send(1); cfg_send(0);
    data_send(1); data_send(0);
    chk("t4_pre_match", w_match, 1);
    chk("t4_pre_count", w_count, 1);
    data_send(1);
    r_clear = 1'b1;
    data_send(0);
    r_clear = 1'b0;
    chk("t4_match", w_match, 0);
    chk("t4_count", w_count, 0);
    chk("t4_seg", w_seg, 8'h3F);
    chk("t4_armed", w_armed, 1);
    data_send(1); data_send(0);
    chk("t4_post_match", w_match, 1);
    chk("t4_post_count", w_count, 1);

    // T5: freeze via ena during a completing bit
    tick(); tick(); tick(); tick();
    chk("t5_seg_idle", w_seg, 8'h06);
    data_send(1);
    r_ena = 1'b0;
    r_data_bit = 1'b0; r_data_valid = 1'b1;
    tick(); tick();
    chk("t5_frz_match", w_match, 0);
    chk("t5_frz_count", w_count, 1);
    chk("t5_frz_seg", w_seg, 8'h06);
    chk("t5_frz_armed", w_armed, 1);
    r_ena = 1'b1; r_data_valid = 1'b0;
    tick();
    chk("t5_nv_match", w_match, 0);
    chk("t5_nv_count", w_count, 1);
    data_send(0);
    chk("t5_resume_match", w_match, 1);
    chk("t5_resume_count", w_count, 2);

    // T6: reload from DETECT, pending hit dropped
    data_send(1);
    r_cfg_load = 1'b1; r_cfg_len = 3'd1;
    data_send(0);
    r_cfg_load = 1'b0;
    chk("t6_drop_match", w_match, 0);
    chk("t6_drop_count", w_count, 2);
    chk("t6_busy", w_busy, 1);
    cfg_send(0);
    chk("t6_busy_mid", w_busy, 1);
    cfg_send(0);
    chk("t6_armed", w_armed, 1);
    data_send(1);
    chk("t6_m1", w_match, 0);
    data_send(0);
    chk("t6_old_pat", w_match, 0);
    data_send(0);
    chk("t6_new_pat", w_match, 1);
    chk("t6_count", w_count, 3);
    chk("t6_seg", w_seg, 8'hCF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
